// File: rtl/me_stage_if.sv
// ---------------------------------------------------------------------------
// me_stage_if
//
// Pipeline-side bundle of the memory-access stage: the EX/MEM register
// outputs flowing into the stage and the MEM/WB values flowing out of it.
//
//   wrt_en                 stage advance (0 = stall)
//   EX_intermediateResult  ALU result / memory address
//   EX_regData2            store data
//   EX_rd                  destination register
//   EX_ME_mux_sel          1 = result comes from a load
//   EX_wrReg               register write enable
//   EX_wrMem               memory / I/O store enable
//   WB_result              writeback data
//   WB_rd                  writeback destination
//   WB_wrReg               writeback enable
//
// master: the upstream side (drives EX_*, observes WB_*).
// slave : the memory-access stage itself.
// ---------------------------------------------------------------------------
interface me_stage_if #(
  parameter int DBITS               = 32,
  parameter int REG_INDEX_BIT_WIDTH = 4
) ();

  logic                           wrt_en;
  logic [DBITS-1:0]               EX_intermediateResult;
  logic [DBITS-1:0]               EX_regData2;
  logic [REG_INDEX_BIT_WIDTH-1:0] EX_rd;
  logic                           EX_ME_mux_sel;
  logic                           EX_wrReg;
  logic                           EX_wrMem;
  logic [DBITS-1:0]               WB_result;
  logic [REG_INDEX_BIT_WIDTH-1:0] WB_rd;
  logic                           WB_wrReg;

  modport master (
    output wrt_en, EX_intermediateResult, EX_regData2, EX_rd,
    output EX_ME_mux_sel, EX_wrReg, EX_wrMem,
    input  WB_result, WB_rd, WB_wrReg
  );

  modport slave (
    input  wrt_en, EX_intermediateResult, EX_regData2, EX_rd,
    input  EX_ME_mux_sel, EX_wrReg, EX_wrMem,
    output WB_result, WB_rd, WB_wrReg
  );

endinterface

// File: rtl/me_stage.sv
// ---------------------------------------------------------------------------
// me_stage
//
// Memory-access stage of the 5-stage pipeline. Decodes the latched EX
// address into either a data-memory word or one of the board I/O registers,
// performs the store or load, and holds the MEM/WB register that feeds
// writeback.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; overrides wrt_en
//   bus    me_stage_if.slave (EX_* inputs, WB_* outputs, wrt_en)
//   KEY    raw push-buttons, active-low
//   SW     raw switches
//   HEX    six 4-bit display digits (register)
//   LEDR   LED register
//
// I/O map (loads zero-extended):
//   ADDR_HEX     r/w  HEX[23:0]
//   ADDR_LEDR    r/w  LEDR[9:0]
//   ADDR_KEY     r    key_state[3:0]; a load clears key_ready
//   ADDR_KEYCTRL r    bit0 = key_ready
//   ADDR_SW      r    sw_state[9:0]
// Any other address is a data-memory access at word addr[DMEM_ADDR_BITS+1:2].
// ---------------------------------------------------------------------------
module me_stage #(
  parameter int               DBITS               = 32,
  parameter int               REG_INDEX_BIT_WIDTH = 4,
  parameter int               DMEM_ADDR_BITS      = 11,
  parameter logic [DBITS-1:0] ADDR_HEX            = 32'hF000_0000,
  parameter logic [DBITS-1:0] ADDR_LEDR           = 32'hF000_0004,
  parameter logic [DBITS-1:0] ADDR_KEY            = 32'hF000_0010,
  parameter logic [DBITS-1:0] ADDR_KEYCTRL        = 32'hF000_0110,
  parameter logic [DBITS-1:0] ADDR_SW             = 32'hF000_0014
) (
  input  logic        clk,
  input  logic        reset,
  me_stage_if.slave   bus,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic [23:0] HEX,
  output logic [9:0]  LEDR
);

  localparam int DMEM_WORDS = 1 << DMEM_ADDR_BITS;

  // Address decode
  logic [DBITS-1:0]          addr_s;
  logic [DMEM_ADDR_BITS-1:0] dmem_idx_s;
  logic                      is_hex_s;
  logic                      is_ledr_s;
  logic                      is_key_s;
  logic                      is_keyctrl_s;
  logic                      is_sw_s;
  logic                      is_io_s;

  // Access qualifiers
  logic                      accept_s;
  logic                      store_s;
  logic                      load_s;
  logic                      key_change_s;
  logic                      key_clear_s;
  logic [DBITS-1:0]          io_rdata_s;

  // Data memory
  logic [DBITS-1:0]          dmem_r [0:DMEM_WORDS-1];
  logic [DBITS-1:0]          dmem_rdata_r;

  // Board I/O state
  logic [23:0]               hex_r;
  logic [9:0]                ledr_r;
  logic [3:0]                key_state_r;
  logic                      key_ready_r;
  logic [9:0]                sw_state_r;

  // MEM/WB register
  logic                           wb_sel_r;
  logic                           wb_io_r;
  logic [DBITS-1:0]               wb_alu_r;
  logic [DBITS-1:0]               wb_io_data_r;
  logic [REG_INDEX_BIT_WIDTH-1:0] wb_rd_r;
  logic                           wb_wrreg_r;
  logic [DBITS-1:0]               wb_result_s;

  assign addr_s       = bus.EX_intermediateResult;
  // Upper address bits are deliberately dropped: memory aliases and wraps.
  assign dmem_idx_s   = addr_s[DMEM_ADDR_BITS+1:2];
  assign is_hex_s     = (addr_s == ADDR_HEX);
  assign is_ledr_s    = (addr_s == ADDR_LEDR);
  assign is_key_s     = (addr_s == ADDR_KEY);
  assign is_keyctrl_s = (addr_s == ADDR_KEYCTRL);
  assign is_sw_s      = (addr_s == ADDR_SW);
  assign is_io_s      = is_hex_s | is_ledr_s | is_key_s | is_keyctrl_s | is_sw_s;

  // Reset wins over wrt_en, so no access is accepted while reset is high.
  assign accept_s     = bus.wrt_en & ~reset;
  assign store_s      = accept_s & bus.EX_wrMem;
  assign load_s       = accept_s & bus.EX_ME_mux_sel;

  assign key_change_s = ((~KEY) != key_state_r);
  assign key_clear_s  = load_s & is_key_s;

  // I/O read mux: value of the addressed I/O register at the access edge.
  always_comb begin
    io_rdata_s = {DBITS{1'b0}};
    if (is_hex_s) begin
      io_rdata_s = DBITS'(hex_r);
    end else if (is_ledr_s) begin
      io_rdata_s = DBITS'(ledr_r);
    end else if (is_key_s) begin
      io_rdata_s = DBITS'(key_state_r);
    end else if (is_keyctrl_s) begin
      io_rdata_s = DBITS'(key_ready_r);
    end else if (is_sw_s) begin
      io_rdata_s = DBITS'(sw_state_r);
    end else begin
      io_rdata_s = {DBITS{1'b0}};
    end
  end

  // Data memory: single port, synchronous read, contents never reset.
  // The read register only advances with the stage so a stalled load keeps
  // presenting its data.
  always_ff @(posedge clk) begin
    if (store_s && !is_io_s) begin
      dmem_r[dmem_idx_s] <= bus.EX_regData2;
    end
    if (accept_s) begin
      dmem_rdata_r <= dmem_r[dmem_idx_s];
    end
  end

  // HEX / LEDR output registers, written by accepted stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_r  <= 24'h00_0000;
      ledr_r <= 10'h000;
    end else if (store_s) begin
      if (is_hex_s) begin
        hex_r <= bus.EX_regData2[23:0];
      end
      if (is_ledr_s) begin
        ledr_r <= bus.EX_regData2[9:0];
      end
    end
  end

  // Input sampling and key_ready flag; sampling runs even during a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_state_r <= 4'h0;
      sw_state_r  <= 10'h000;
      key_ready_r <= 1'b0;
    end else begin
      key_state_r <= ~KEY;
      sw_state_r  <= SW;
      // A new key event takes priority over a simultaneous clearing read.
      if (key_change_s) begin
        key_ready_r <= 1'b1;
      end else if (key_clear_s) begin
        key_ready_r <= 1'b0;
      end
    end
  end

  // MEM/WB register: advances only with wrt_en. The I/O value is captured
  // here so later I/O activity cannot disturb a held writeback value.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_sel_r     <= 1'b0;
      wb_io_r      <= 1'b0;
      wb_alu_r     <= {DBITS{1'b0}};
      wb_io_data_r <= {DBITS{1'b0}};
      wb_rd_r      <= {REG_INDEX_BIT_WIDTH{1'b0}};
      wb_wrreg_r   <= 1'b0;
    end else if (bus.wrt_en) begin
      wb_sel_r     <= bus.EX_ME_mux_sel;
      wb_io_r      <= is_io_s;
      wb_alu_r     <= bus.EX_intermediateResult;
      wb_io_data_r <= io_rdata_s;
      wb_rd_r      <= bus.EX_rd;
      wb_wrreg_r   <= bus.EX_wrReg;
    end
  end

  // Writeback result select from the latched MEM/WB fields.
  always_comb begin
    wb_result_s = {DBITS{1'b0}};
    if (!wb_sel_r) begin
      wb_result_s = wb_alu_r;
    end else if (wb_io_r) begin
      wb_result_s = wb_io_data_r;
    end else begin
      wb_result_s = dmem_rdata_r;
    end
  end

  assign bus.WB_result = wb_result_s;
  assign bus.WB_rd     = wb_rd_r;
  assign bus.WB_wrReg  = wb_wrreg_r;
  assign HEX           = hex_r;
  assign LEDR          = ledr_r;

endmodule

// File: tb/tb_me_stage.sv
// ---------------------------------------------------------------------------
// tb_me_stage
//
// Self-checking bench for me_stage. A behavioural model (associative-array
// memory plus plain variables for the I/O registers) is stepped alongside
// every clock; directed scenario tasks compare against constants and the
// randomized task compares against the model.
// ---------------------------------------------------------------------------
module tb_me_stage;

  localparam logic [31:0] A_HEX     = 32'hF000_0000;
  localparam logic [31:0] A_LEDR    = 32'hF000_0004;
  localparam logic [31:0] A_KEY     = 32'hF000_0010;
  localparam logic [31:0] A_KEYCTRL = 32'hF000_0110;
  localparam logic [31:0] A_SW      = 32'hF000_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [23:0] HEX;
  logic [9:0]  LEDR;

  always #5 clk = ~clk;

  me_stage_if #(.DBITS(32), .REG_INDEX_BIT_WIDTH(4)) bus ();

  me_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .KEY   (KEY),
    .SW    (SW),
    .HEX   (HEX),
    .LEDR  (LEDR)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state
  logic [31:0] mem_m [int];
  logic [23:0] hex_m;
  logic [9:0]  ledr_m;
  logic [3:0]  ks_m;
  logic        kr_m;
  logic [9:0]  sw_m;
  logic [31:0] exp_result;
  logic [3:0]  exp_rd;
  logic        exp_wr;
  bit          exp_valid;

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] ld;
    bit          ldv;
    bit          io;
    logic        new_kr;
    int          idx;
    a   = bus.EX_intermediateResult;
    d   = bus.EX_regData2;
    idx = int'(a[12:2]);
    io  = (a == A_HEX) || (a == A_LEDR) || (a == A_KEY) || (a == A_KEYCTRL) || (a == A_SW);
    if (reset) begin
      hex_m = 24'h0; ledr_m = 10'h0; ks_m = 4'h0; kr_m = 1'b0; sw_m = 10'h0;
      exp_result = 32'h0; exp_rd = 4'h0; exp_wr = 1'b0; exp_valid = 1'b1;
    end else begin
      ldv = 1'b1;
      ld  = 32'h0;
      if (a == A_HEX)          ld = {8'h0, hex_m};
      else if (a == A_LEDR)    ld = {22'h0, ledr_m};
      else if (a == A_KEY)     ld = {28'h0, ks_m};
      else if (a == A_KEYCTRL) ld = {31'h0, kr_m};
      else if (a == A_SW)      ld = {22'h0, sw_m};
      else if (mem_m.exists(idx)) ld = mem_m[idx];
      else ldv = 1'b0;
      new_kr = kr_m;
      if (bus.wrt_en) begin
        exp_rd = bus.EX_rd;
        exp_wr = bus.EX_wrReg;
        if (bus.EX_ME_mux_sel) begin
          exp_result = ld; exp_valid = ldv;
        end else begin
          exp_result = a; exp_valid = 1'b1;
        end
        if (bus.EX_wrMem) begin
          if (a == A_HEX)       hex_m = d[23:0];
          else if (a == A_LEDR) ledr_m = d[9:0];
          else if (!io)         mem_m[idx] = d;
        end
        if (bus.EX_ME_mux_sel && a == A_KEY) new_kr = 1'b0;
      end
      if ((~KEY) != ks_m) new_kr = 1'b1;
      kr_m = new_kr;
      ks_m = ~KEY;
      sw_m = SW;
    end
  endtask

  // Drive one stage transaction, step the model, and move to #1 after the edge.
  task automatic cycle(input bit en, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] rd, input bit sel, input bit wrreg, input bit wrmem);
    bus.wrt_en                = en;
    bus.EX_intermediateResult = addr;
    bus.EX_regData2           = data;
    bus.EX_rd                 = rd;
    bus.EX_ME_mux_sel         = sel;
    bus.EX_wrReg              = wrreg;
    bus.EX_wrMem              = wrmem;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h1234, 32'h0, 4'h7, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (bus.WB_result !== 32'h0 || bus.WB_wrReg !== 1'b0 || bus.WB_rd !== 4'h0)
      $display("FAIL reset_wb: got result=%h rd=%h wr=%b, exp 0/0/0", bus.WB_result, bus.WB_rd, bus.WB_wrReg);
    else pass_cnt++;
    reset = 1'b0;
    cycle(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (bus.WB_result !== 32'h0 || bus.WB_wrReg !== 1'b0)
      $display("FAIL zero_op_wb: got result=%h wr=%b, exp 0/0", bus.WB_result, bus.WB_wrReg);
    else pass_cnt++;
    total_cnt++;
    if (HEX !== 24'h0 || LEDR !== 10'h0)
      $display("FAIL reset_io: got HEX=%h LEDR=%h, exp 0/0", HEX, LEDR);
    else pass_cnt++;
  endtask

  task automatic test_mem_store_load();
    cycle(1'b1, 32'h40, 32'hDEADBEEF, 4'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h40, 32'h0, 4'h5, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (bus.WB_result !== 32'hDEADBEEF || bus.WB_rd !== 4'h5 || bus.WB_wrReg !== 1'b1)
      $display("FAIL mem_load: got result=%h rd=%h wr=%b, exp deadbeef/5/1", bus.WB_result, bus.WB_rd, bus.WB_wrReg);
    else pass_cnt++;
  endtask

  task automatic test_alias();
    cycle(1'b1, 32'h40,   32'h1, 4'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h2040, 32'h2, 4'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h43,   32'h0, 4'h2, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (bus.WB_result !== 32'h2)
      $display("FAIL mem_alias: got %h, exp 2", bus.WB_result);
    else pass_cnt++;
  endtask

  task automatic test_io();
    cycle(1'b1, A_HEX, 32'hFF12_3456, 4'h0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (HEX !== 24'h123456) $display("FAIL hex_store: got %h, exp 123456", HEX);
    else pass_cnt++;
    cycle(1'b1, A_LEDR, 32'h0000_FFFF, 4'h0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (LEDR !== 10'h3FF) $display("FAIL ledr_store: got %h, exp 3ff", LEDR);
    else pass_cnt++;
    cycle(1'b1, A_SW, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (HEX !== 24'h123456 || LEDR !== 10'h3FF)
      $display("FAIL sw_store_ignored: got HEX=%h LEDR=%h, exp 123456/3ff", HEX, LEDR);
    else pass_cnt++;
    SW = 10'h2A5;
    cycle(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, A_SW, 32'h0, 4'h1, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (bus.WB_result !== 32'h2A5) $display("FAIL sw_load: got %h, exp 2a5", bus.WB_result);
    else pass_cnt++;
    cycle(1'b1, A_HEX, 32'h0, 4'h1, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (bus.WB_result !== 32'h0012_3456) $display("FAIL hex_load: got %h, exp 123456", bus.WB_result);
    else pass_cnt++;
  endtask

  task automatic test_keys();
    KEY = 4'hE;
    cycle(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, A_KEYCTRL, 32'h0, 4'h1, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (bus.WB_result !== 32'h1) $display("FAIL keyctrl_set: got %h, exp 1", bus.WB_result);
    else pass_cnt++;
    cycle(1'b1, A_KEY, 32'h0, 4'h1, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (bus.WB_result !== 32'h1) $display("FAIL key_load: got %h, exp 1", bus.WB_result);
    else pass_cnt++;
    cycle(1'b1, A_KEYCTRL, 32'h0, 4'h1, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (bus.WB_result !== 32'h0) $display("FAIL keyctrl_clr: got %h, exp 0", bus.WB_result);
    else pass_cnt++;
    // New key event in the same cycle as a clearing read: set must win.
    KEY = 4'hC;
    cycle(1'b1, A_KEY, 32'h0, 4'h1, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (bus.WB_result !== 32'h1) $display("FAIL key_old_state: got %h, exp 1", bus.WB_result);
    else pass_cnt++;
    cycle(1'b1, A_KEYCTRL, 32'h0, 4'h1, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (bus.WB_result !== 32'h1) $display("FAIL set_beats_clear: got %h, exp 1", bus.WB_result);
    else pass_cnt++;
    cycle(1'b1, A_KEY, 32'h0, 4'h1, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (bus.WB_result !== 32'h3) $display("FAIL key_new_state: got %h, exp 3", bus.WB_result);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    cycle(1'b1, 32'h7, 32'h0, 4'h3, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (bus.WB_result !== 32'h7) $display("FAIL alu_result: got %h, exp 7", bus.WB_result);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h40, 32'hBAD0 + i, 4'h9, i[0], 1'b0, 1'b1);
      total_cnt++;
      if (bus.WB_result !== 32'h7 || bus.WB_rd !== 4'h3 || bus.WB_wrReg !== 1'b1)
        $display("FAIL stall_hold_%0d: got result=%h rd=%h wr=%b, exp 7/3/1", i, bus.WB_result, bus.WB_rd, bus.WB_wrReg);
      else pass_cnt++;
    end
    cycle(1'b1, 32'h40, 32'h0, 4'h4, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (bus.WB_result !== 32'h2) $display("FAIL stall_no_store: got %h, exp 2", bus.WB_result);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    cycle(1'b1, 32'h55, 32'h0, 4'h6, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, A_HEX, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 1'b1);
      total_cnt++;
      if (bus.WB_result !== 32'h0 || bus.WB_rd !== 4'h0 || bus.WB_wrReg !== 1'b0 || HEX !== 24'h0 || LEDR !== 10'h0)
        $display("FAIL reset_stall_%0d: got result=%h rd=%h wr=%b HEX=%h LEDR=%h, exp all 0",
                 i, bus.WB_result, bus.WB_rd, bus.WB_wrReg, HEX, LEDR);
      else pass_cnt++;
    end
    cycle(1'b1, 32'h66, 32'h0, 4'h2, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (bus.WB_result !== 32'h66 || bus.WB_rd !== 4'h2)
      $display("FAIL resume_after_reset: got result=%h rd=%h, exp 66/2", bus.WB_result, bus.WB_rd);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [31:0] data;
    int          kind;
    bit          en;
    for (int n = 0; n < 400; n++) begin
      en   = ($urandom_range(0, 4) != 0);
      data = $urandom;
      kind = $urandom_range(0, 9);
      case ($urandom_range(0, 5))
        0:       addr = A_HEX;
        1:       addr = A_LEDR;
        2:       addr = A_KEY;
        3:       addr = A_KEYCTRL;
        4:       addr = A_SW;
        default: addr = {$urandom_range(0, 15) * 32'h2000} + {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      endcase
      SW = 10'($urandom);
      if ($urandom_range(0, 5) == 0) KEY = 4'($urandom);
      if (kind < 4)      cycle(en, addr, data, 4'($urandom), 1'b0, 1'b0, 1'b1);
      else if (kind < 8) cycle(en, addr, data, 4'($urandom), 1'b1, 1'($urandom), 1'b0);
      else               cycle(en, data, 32'h0, 4'($urandom), 1'b0, 1'($urandom), 1'b0);
      total_cnt++;
      if (bus.WB_rd !== exp_rd || bus.WB_wrReg !== exp_wr)
        $display("FAIL rand_wb_ctl[%0d]: got rd=%h wr=%b, exp %h/%b", n, bus.WB_rd, bus.WB_wrReg, exp_rd, exp_wr);
      else pass_cnt++;
      total_cnt++;
      if (HEX !== hex_m || LEDR !== ledr_m)
        $display("FAIL rand_io[%0d]: got HEX=%h LEDR=%h, exp %h/%h", n, HEX, LEDR, hex_m, ledr_m);
      else pass_cnt++;
      if (exp_valid) begin
        total_cnt++;
        if (bus.WB_result !== exp_result)
          $display("FAIL rand_result[%0d]: got %h, exp %h", n, bus.WB_result, exp_result);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    KEY   = 4'hF;
    SW    = 10'h000;
    bus.wrt_en                = 1'b0;
    bus.EX_intermediateResult = 32'h0;
    bus.EX_regData2           = 32'h0;
    bus.EX_rd                 = 4'h0;
    bus.EX_ME_mux_sel         = 1'b0;
    bus.EX_wrReg              = 1'b0;
    bus.EX_wrMem              = 1'b0;
    #2;
    test_reset();
    test_mem_store_load();
    test_alias();
    test_io();
    test_keys();
    test_stall();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
